wb_data_ram: RTL

- Wishbone B4 classic slave data memory; it answers the CPU data-side bus master in the minimal SOPC.
- Replaces the zero-latency combinational data RAM with a registered responder that has a programmable wait-state count, so the CPU stall path is exercised in simulation.
- Instantiated in the SOPC top beside the instruction ROM. It is driven by the same clock and reset that the top-level testbench generates.

---
 rtl/wb_data_ram_pkg.sv | 23 ++
 rtl/wb_data_ram_array.sv | 44 ++++
 rtl/wb_data_ram.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/wb_data_ram_pkg.sv
// rtl/wb_data_ram_pkg.sv - shared constants, state encoding and helpers for the data RAM slave.
package wb_data_ram_pkg;

  localparam logic RstEnable    = 1'b1;
  localparam logic RstDisable   = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_ram_state_e;

  function automatic logic [CNT_W-1:0] wait_init(input int wait_cycles);
    return (wait_cycles > 0) ? CNT_W'(wait_cycles - 1) : '0;
  endfunction

endpackage

// File: rtl/wb_data_ram_array.sv
// rtl/wb_data_ram_array.sv - single-port synchronous RAM, byte-lane writes, registered read.
module wb_data_ram_array
  import wb_data_ram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic              clr_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i && (we_i == WriteEnable)) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (sel_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // The read register only moves on a read or an error response, so it holds between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (en_i && (we_i == WriteDisable)) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_data_ram.sv
// rtl/wb_data_ram.sv - Wishbone classic data RAM slave with programmable wait states.
// Optional out-of-range error termination when WB_RAM_ERR_EN is defined.
module wb_data_ram
  import wb_data_ram_pkg::*;
#(
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int WAIT_CYCLES    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [SEL_W-1:0]  wb_sel_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o
);

  localparam int AW = MEM_WORDS_LOG2;
  localparam logic [CNT_W-1:0] WaitInit = wait_init(WAIT_CYCLES);

  wb_ram_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  logic              we_q, oor_q;
  logic [AW-1:0]     idx_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] dat_q;

  logic              req, live_oor, enter_resp;
  logic              cur_we, cur_oor;
  logic [AW-1:0]     cur_idx;
  logic [SEL_W-1:0]  cur_sel;
  logic [DATA_W-1:0] cur_dat;
  logic              ram_en, ram_we, ram_clr;
  logic              unused_adr;

  assign req = wb_cyc_i & wb_stb_i;

`ifdef WB_RAM_ERR_EN
  assign live_oor   = |wb_adr_i[31:AW+2];
  assign unused_adr = ^wb_adr_i[1:0];
`else
  assign live_oor   = 1'b0;
  assign unused_adr = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};
`endif

  // With no wait states the RAM fires on the accepting edge, before the latch holds the request.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we  = wb_we_i;
      cur_oor = live_oor;
      cur_idx = wb_adr_i[AW+1:2];
      cur_sel = wb_sel_i;
      cur_dat = wb_dat_i;
    end else begin
      cur_we  = we_q;
      cur_oor = oor_q;
      cur_idx = idx_q;
      cur_sel = sel_q;
      cur_dat = dat_q;
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && req) begin
      we_q  <= wb_we_i;
      oor_q <= live_oor;
      idx_q <= wb_adr_i[AW+1:2];
      sel_q <= wb_sel_i;
      dat_q <= wb_dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = WaitInit;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset on the entering edge must drop the transfer, so the RAM strobes are gated by rst.
  always_comb begin
    enter_resp = (state_d == RESP) && (state_q != RESP);
    ram_en     = 1'b0;
    ram_we     = WriteDisable;
    ram_clr    = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    if (enter_resp) begin
      ack_d = !cur_oor;
      err_d = cur_oor;
      if (rst == RstDisable) begin
        ram_en  = !cur_oor;
        ram_we  = cur_we;
        ram_clr = cur_oor;
      end
    end
  end

  wb_data_ram_array #(
    .ADDR_W (AW)
  ) u_array (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .clr_i   (ram_clr),
    .sel_i   (cur_sel),
    .addr_i  (cur_idx),
    .wdata_i (cur_dat),
    .rdata_o (wb_dat_o)
  );

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule
